cfi_mailbox_rx: RTL and testbench

- AXI4 write/read responder (subordinate) that terminates the CFI log traffic issued by the CFI backend over the crossbar.
- Buffers received 64-bit log words in an internal FIFO and raises a doorbell interrupt toward the monitoring core.
- The monitoring core drains the FIFO, checks status and acknowledges the doorbell over the same AXI port.
- Sits on the crossbar in place of the external SCMI mailbox for CFI logs.

---
 rtl/cfi_mailbox_rx.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cfi_mailbox_rx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_mailbox_rx.sv
// cfi_mailbox_rx: AXI4 subordinate that queues CFI log words in a FIFO and raises a doorbell.
// Optional: define CFI_MAILBOX_TIMESTAMP_EN to add a free-running cycle counter and the TIMESTAMP register.

package ariane_axi;
    localparam int unsigned IdWidth = 4;
    typedef logic [IdWidth-1:0] id_t;
    typedef struct packed { id_t id; logic [63:0] addr; logic [7:0] len; } ax_chan_t;
    typedef struct packed { logic [63:0] data; logic last; } w_chan_t;
    typedef struct packed { id_t id; logic [1:0] resp; } b_chan_t;
    typedef struct packed { id_t id; logic [63:0] data; logic [1:0] resp; logic last; } r_chan_t;
    typedef struct packed {
        ax_chan_t aw; logic aw_valid;
        w_chan_t  w;  logic w_valid;
        logic     b_ready;
        ax_chan_t ar; logic ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid;  b_chan_t b;
        logic r_valid;  r_chan_t r;
    } resp_t;
endpackage

module cfi_mailbox_rx #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [63:0] ADDR_BASE = 64'h1000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_rsp_o,
    output logic              doorbell_o,
    output logic              overflow_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] REG_LOG    = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DB     = 3'd2;
    localparam logic [2:0] REG_ACK    = 3'd3;
    localparam logic [2:0] REG_TS     = 3'd4;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Holds the AW/AR readies low for the first cycle out of reset.
    logic up_q;

    logic [1:0]              wstate_q, wstate_d;
    ariane_axi::id_t         wid_q, wid_d;
    logic [63:3]             waddr_q, waddr_d;
    logic [7:0]              wlen_q, wlen_d;
    logic                    wfirst_q, wfirst_d;
    logic [1:0]              bresp_q, bresp_d;

    logic [0:0]              rstate_q, rstate_d;
    ariane_axi::id_t         rid_q, rid_d;
    logic [63:3]             raddr_q, raddr_d;
    logic [7:0]              rlen_q, rlen_d, rbeat_q, rbeat_d;

    logic [63:0]             mem_q [DEPTH];
    logic [PtrW-1:0]         wptr_q, rptr_q;
    logic [CntW-1:0]         cnt_q;
    logic                    db_q, db_d, ovf_q, ovf_d;
    logic                    push, pop, full, empty;
    logic [63:0]             rdata;
    logic [1:0]              rresp;
    logic                    w_hit, r_hit;
    logic [2:0]              w_idx, r_idx;
    logic                    unused_addr_lsbs;

`ifdef CFI_MAILBOX_TIMESTAMP_EN
    logic [63:0]             ts_q, ts_cap_q, ts_cap_d;
`endif

    assign unused_addr_lsbs = ^{axi_req_i.aw.addr[2:0], axi_req_i.ar.addr[2:0]};

    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign w_hit = (waddr_q[63:6] == ADDR_BASE[63:6]);
    assign r_hit = (raddr_q[63:6] == ADDR_BASE[63:6]);
    assign w_idx = waddr_q[5:3];
    assign r_idx = raddr_q[5:3];

    // Read data is live FIFO/status state; the value that counts is the one at the R handshake.
    always_comb begin
        rdata = '0;
        rresp = RESP_OKAY;
        if (rlen_q != 8'd0) begin
            rresp = RESP_SLVERR;
        end else if (!r_hit) begin
            rresp = RESP_DECERR;
        end else begin
            case (r_idx)
                REG_LOG:    if (empty) rresp = RESP_SLVERR; else rdata = mem_q[rptr_q];
                REG_STATUS: rdata = {48'd0, 8'(cnt_q), 5'd0, ovf_q, full, empty};
                REG_DB, REG_ACK: rdata = '0;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
                REG_TS:     rdata = ts_cap_q;
`endif
                default:    rresp = RESP_DECERR;
            endcase
        end
    end

    assign pop = (rstate_q == R_DATA) && axi_req_i.r_ready && (rlen_q == 8'd0)
               && r_hit && (r_idx == REG_LOG) && !empty;

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rbeat_d  = rbeat_q;
        case (rstate_q)
            R_IDLE: if (up_q && axi_req_i.ar_valid) begin
                rid_d    = axi_req_i.ar.id;
                raddr_d  = axi_req_i.ar.addr[63:3];
                rlen_d   = axi_req_i.ar.len;
                rbeat_d  = 8'd0;
                rstate_d = R_DATA;
            end
            default: if (axi_req_i.r_ready) begin
                if (rbeat_q == rlen_q) rstate_d = R_IDLE;
                else                   rbeat_d  = rbeat_q + 8'd1;
            end
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wfirst_d = wfirst_q;
        bresp_d  = bresp_q;
        db_d     = db_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
        ts_cap_d = ts_cap_q;
`endif
        case (wstate_q)
            W_IDLE: if (up_q && axi_req_i.aw_valid) begin
                wid_d    = axi_req_i.aw.id;
                waddr_d  = axi_req_i.aw.addr[63:3];
                wlen_d   = axi_req_i.aw.len;
                wfirst_d = 1'b1;
                bresp_d  = (axi_req_i.aw.len != 8'd0) ? RESP_SLVERR : RESP_OKAY;
                wstate_d = W_DATA;
            end
            W_DATA: if (axi_req_i.w_valid) begin
                wfirst_d = 1'b0;
                if (wfirst_q && wlen_q == 8'd0) begin
                    if (!w_hit) begin
                        bresp_d = RESP_DECERR;
                    end else begin
                        case (w_idx)
                            // A same-cycle pop frees the slot before the push needs it.
                            REG_LOG: if (full && !pop) begin
                                ovf_d   = 1'b1;
                                bresp_d = RESP_SLVERR;
                            end else begin
                                push = 1'b1;
                            end
                            REG_STATUS: bresp_d = RESP_SLVERR;
                            REG_DB: begin
                                db_d = 1'b1;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
                                ts_cap_d = ts_q;
`endif
                            end
                            REG_ACK: begin
                                db_d  = 1'b0;
                                ovf_d = 1'b0;
                            end
`ifdef CFI_MAILBOX_TIMESTAMP_EN
                            REG_TS: bresp_d = RESP_SLVERR;
`endif
                            default: bresp_d = RESP_DECERR;
                        endcase
                    end
                end
                if (axi_req_i.w.last) wstate_d = W_RESP;
            end
            W_RESP: if (axi_req_i.b_ready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            up_q     <= 1'b0;
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wfirst_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            up_q     <= 1'b1;
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wfirst_q <= wfirst_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rbeat_q  <= rbeat_d;
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            cnt_q    <= cnt_q + CntW'(push) - CntW'(pop);
            db_q     <= db_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= axi_req_i.w.data;
    end

`ifdef CFI_MAILBOX_TIMESTAMP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q     <= ts_q + 64'd1;
            ts_cap_q <= ts_cap_d;
        end
    end
`endif

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = up_q && (wstate_q == W_IDLE);
        axi_rsp_o.w_ready  = (wstate_q == W_DATA);
        axi_rsp_o.b_valid  = (wstate_q == W_RESP);
        axi_rsp_o.b.id     = wid_q;
        axi_rsp_o.b.resp   = bresp_q;
        axi_rsp_o.ar_ready = up_q && (rstate_q == R_IDLE);
        axi_rsp_o.r_valid  = (rstate_q == R_DATA);
        axi_rsp_o.r.id     = rid_q;
        axi_rsp_o.r.data   = rdata;
        axi_rsp_o.r.resp   = rresp;
        axi_rsp_o.r.last   = (rbeat_q == rlen_q);
    end

    assign doorbell_o = db_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cfi_mailbox_rx.sv
// Bench for cfi_mailbox_rx: directed test-plan sequence plus randomized concurrent traffic,
// checked against a transaction-level model (queue + flags) on every falling clock edge.
module tb_cfi_mailbox_rx;
    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h1000_0000;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam int TMO = 200;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
    localparam logic [1:0] TS_WRESP = SLVERR;
`else
    localparam logic [1:0] TS_WRESP = DECERR;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
    logic [3:0] aw_id = 0, ar_id = 0;
    logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0;
    logic [7:0] aw_len = 0, ar_len = 0;
    ariane_axi::req_t req;
    ariane_axi::resp_t rsp;
    logic doorbell, overflow;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    always_comb begin
        req = '0;
        req.aw.id = aw_id; req.aw.addr = aw_addr; req.aw.len = aw_len; req.aw_valid = aw_valid;
        req.w.data = w_data; req.w.last = w_last; req.w_valid = w_valid; req.b_ready = b_ready;
        req.ar.id = ar_id; req.ar.addr = ar_addr; req.ar.len = ar_len; req.ar_valid = ar_valid;
        req.r_ready = r_ready;
    end

    cfi_mailbox_rx #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_rsp_o(rsp),
        .doorbell_o(doorbell), .overflow_o(overflow));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq[$];
    bit m_db, m_ovf, m_up;
    bit w_act, w_done, w_first, r_act;
    logic [3:0] m_wid, m_rid;
    logic [63:0] m_waddr, m_raddr;
    int m_wlen, m_rlen, m_rbeat;
    logic [1:0] m_bresp;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
    logic [63:0] m_cyc, m_ts;
`endif

    function automatic int reg_of(input logic [63:0] a);
        if (a < BASE || (a - BASE) >= 64) return -1;
        return int'((a - BASE) / 8);
    endfunction

    always @(negedge clk) begin
        logic [63:0] e_d;
        logic [1:0] e_r;
        if (rst) begin
            check("rst_awready", rsp.aw_ready, 0); check("rst_wready", rsp.w_ready, 0);
            check("rst_bvalid", rsp.b_valid, 0);   check("rst_arready", rsp.ar_ready, 0);
            check("rst_rvalid", rsp.r_valid, 0);   check("rst_doorbell", doorbell, 0);
            check("rst_overflow", overflow, 0);
            mq.delete(); m_db = 0; m_ovf = 0; m_up = 0; w_act = 0; w_done = 0; r_act = 0;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
            m_cyc = 0; m_ts = 0;
`endif
        end else begin
            check("awready", rsp.aw_ready, m_up && !w_act);
            check("wready", rsp.w_ready, w_act && !w_done);
            check("bvalid", rsp.b_valid, w_done);
            check("arready", rsp.ar_ready, m_up && !r_act);
            check("rvalid", rsp.r_valid, r_act);
            check("doorbell", doorbell, m_db);
            check("overflow", overflow, m_ovf);
            if (w_done) begin
                check("bid", rsp.b.id, m_wid);
                check("bresp", rsp.b.resp, m_bresp);
            end
            // read beat first: a pop frees space for a same-cycle push and never sees it
            if (r_act && r_ready) begin
                e_d = 0; e_r = OKAY;
                if (m_rlen != 0) e_r = SLVERR;
                else case (reg_of(m_raddr))
                    0: if (mq.size() == 0) e_r = SLVERR; else e_d = mq.pop_front();
                    1: e_d = (64'(mq.size()) << 8) | (64'(m_ovf) << 2)
                           | (64'(mq.size() == DEPTH) << 1) | 64'(mq.size() == 0);
                    2, 3: e_d = 0;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
                    4: e_d = m_ts;
`endif
                    default: e_r = DECERR;
                endcase
                check("rid", rsp.r.id, m_rid);
                check("rdata", rsp.r.data, e_d);
                check("rresp", rsp.r.resp, e_r);
                check("rlast", rsp.r.last, m_rbeat == m_rlen);
                if (m_rbeat == m_rlen) r_act = 0; else m_rbeat++;
            end
            if (w_act && !w_done && w_valid) begin
                if (w_first && m_wlen == 0) begin
                    case (reg_of(m_waddr))
                        0: if (mq.size() >= DEPTH) begin m_ovf = 1; m_bresp = SLVERR; end
                           else mq.push_back(w_data);
                        1: m_bresp = SLVERR;
                        2: begin
                            m_db = 1;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
                            m_ts = m_cyc;
`endif
                        end
                        3: begin m_db = 0; m_ovf = 0; end
                        4: m_bresp = TS_WRESP;
                        default: m_bresp = DECERR;
                    endcase
                end
                w_first = 0;
                if (w_last) w_done = 1;
            end
            if (w_done && b_ready && rsp.b_valid) begin w_act = 0; w_done = 0; end
            if (m_up && !w_act && aw_valid) begin
                w_act = 1; w_done = 0; w_first = 1;
                m_wid = aw_id; m_waddr = aw_addr; m_wlen = int'(aw_len);
                m_bresp = (aw_len != 0) ? SLVERR : OKAY;
            end
            if (m_up && !r_act && ar_valid) begin
                r_act = 1; m_rid = ar_id; m_raddr = ar_addr; m_rlen = int'(ar_len); m_rbeat = 0;
            end
            m_up = 1;
`ifdef CFI_MAILBOX_TIMESTAMP_EN
            m_cyc++;
`endif
        end
    end

    // ---------------- drivers ----------------
    bit gaps = 0;

    function automatic logic sig_of(input int which);
        case (which)
            0: return rsp.aw_ready;
            1: return rsp.w_ready;
            2: return rsp.b_valid;
            3: return rsp.ar_ready;
            default: return rsp.r_valid;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!sig_of(which) && n < TMO) begin n++; @(negedge clk); end
        ok = sig_of(which);
        if (!ok) check({nm, "_timeout"}, sig_of(which), 1);
    endtask

    task automatic gap();
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [63:0] addr, input int len, input logic [63:0] data,
                             output logic [1:0] resp);
        bit ok;
        resp = 2'b01;
        aw_id = 4'($urandom_range(0, 15)); aw_addr = addr; aw_len = 8'(len); aw_valid = 1;
        wait_sig(0, "aw", ok);
        @(posedge clk); #1 aw_valid = 0;
        if (!ok) return;
        for (int b = 0; b <= len; b++) begin
            gap();
            w_valid = 1; w_last = (b == len);
            w_data = (b == 0) ? data : {$urandom, $urandom};
            wait_sig(1, "w", ok);
            @(posedge clk); #1 w_valid = 0; w_last = 0;
            if (!ok) return;
        end
        gap();
        b_ready = 1;
        wait_sig(2, "b", ok);
        if (ok) resp = rsp.b.resp;
        @(posedge clk); #1 b_ready = 0;
    endtask

    task automatic axi_read(input logic [63:0] addr, input int len,
                            output logic [63:0] d0, output logic [1:0] r0, output int last_at);
        bit ok;
        d0 = '1; r0 = 2'b01; last_at = 0;
        ar_id = 4'($urandom_range(0, 15)); ar_addr = addr; ar_len = 8'(len); ar_valid = 1;
        wait_sig(3, "ar", ok);
        @(posedge clk); #1 ar_valid = 0;
        if (!ok) return;
        for (int b = 0; b <= len; b++) begin
            gap();
            r_ready = 1;
            wait_sig(4, "r", ok);
            if (ok) begin
                if (b == 0) begin d0 = rsp.r.data; r0 = rsp.r.resp; end
                if (rsp.r.last && last_at == 0) last_at = b + 1;
            end
            @(posedge clk); #1 r_ready = 0;
            if (!ok) return;
        end
    endtask

    function automatic logic [63:0] rnd_addr(input bit rd);
        int k = $urandom_range(0, 15);
        if (k < (rd ? 9 : 7)) return BASE;
        case (k)
            9:  return BASE + 64'h08;
            10: return BASE + 64'h10;
            11: return BASE + 64'h18;
            12: return BASE + 64'h20;
            13: return BASE + 64'h28;
            14: return BASE + 64'h38;
            default: return BASE + 64'h40;
        endcase
    endfunction

    initial begin
        logic [1:0] bresp, rresp, bresp2, rresp2;
        logic [63:0] d, d2;
        int la, la2, nok;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        check("reset_awready", rsp.aw_ready, 0);
        check("reset_bvalid", rsp.b_valid, 0);
        check("reset_doorbell", doorbell, 0);
        rst = 0;

        // single push, status, pop
        axi_write(BASE, 0, 64'hDEAD_BEEF_0000_0001, bresp);
        check("t1_bresp", bresp, OKAY);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t1_status", d, 64'h100);
        axi_read(BASE, 0, d, rresp, la);
        check("t1_pop_data", d, 64'hDEAD_BEEF_0000_0001);
        check("t1_pop_resp", rresp, OKAY);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t1_status_empty", d, 64'h1);

        // fill past DEPTH
        nok = 0;
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(BASE, 0, 64'h1000 + 64'(i), bresp);
            if (bresp == OKAY) nok++;
        end
        check("t2_okay_count", 64'(nok), 64'(DEPTH));
        axi_write(BASE, 0, 64'h1000 + 64'(DEPTH), bresp);
        check("t2_drop_bresp", bresp, SLVERR);
        check("t2_overflow", overflow, 1);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t2_status_full", d, 64'h1006);
        axi_write(BASE + 8'h18, 0, 64'h0, bresp);
        check("t2_ack_overflow", overflow, 0);

        // same-cycle push and pop with the FIFO full
        aw_addr = BASE; aw_len = 0; aw_id = 5; aw_valid = 1;
        ar_addr = BASE; ar_len = 0; ar_id = 6; ar_valid = 1;
        w_data = 64'hC0FFEE; w_last = 1; w_valid = 1; r_ready = 1; b_ready = 1;
        @(negedge clk); check("pp_addr_ready", {rsp.aw_ready, rsp.ar_ready}, 2'b11);
        @(posedge clk); #1 aw_valid = 0; ar_valid = 0;
        @(negedge clk);
        check("pp_wr_rv", {rsp.w_ready, rsp.r_valid}, 2'b11);
        check("pp_rdata", rsp.r.data, 64'h1000);
        check("pp_rresp", rsp.r.resp, OKAY);
        @(posedge clk); #1 w_valid = 0; w_last = 0; r_ready = 0;
        @(negedge clk);
        check("pp_bresp", {rsp.b_valid, rsp.b.resp}, {1'b1, OKAY});
        @(posedge clk); #1 b_ready = 0;
        axi_read(BASE + 8, 0, d, rresp, la);
        check("pp_status", d, 64'h1002);

        // doorbell set and acknowledge
        axi_write(BASE + 8'h10, 0, 64'h0, bresp);
        check("t3_doorbell_set", doorbell, 1);
        axi_read(BASE + 8'h10, 0, d, rresp, la);
        check("t3_db_read", {d, rresp}, {64'h0, OKAY});
        axi_write(BASE + 8'h18, 0, 64'h0, bresp);
        check("t3_doorbell_clr", doorbell, 0);

        // multi-beat bursts are errors with no side effect
        fork
            axi_write(BASE, 3, 64'h77, bresp2);
            axi_read(BASE, 1, d2, rresp2, la2);
        join
        check("t4_burst_bresp", bresp2, SLVERR);
        check("t4_burst_rdata", {d2, rresp2}, {64'h0, SLVERR});
        check("t4_burst_rlast_at", 64'(la2), 64'd2);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t4_status", d, 64'h1002);

        // drain, then empty read and unmapped write
        for (int i = 0; i < DEPTH; i++) axi_read(BASE, 0, d, rresp, la);
        check("t5_last_word", d, 64'hC0FFEE);
        axi_read(BASE, 0, d, rresp, la);
        check("t5_empty_read", {d, rresp}, {64'h0, SLVERR});
        axi_write(BASE + 8'h28, 0, 64'h99, bresp);
        check("t5_decerr", bresp, DECERR);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t5_status", d, 64'h1);

        // reset pulse while the write FSM sits in W_DATA
        axi_write(BASE + 8'h10, 0, 64'h0, bresp);
        axi_write(BASE, 0, 64'h55, bresp);
        aw_addr = BASE; aw_len = 0; aw_valid = 1;
        wait_sig(0, "rst_aw", ok);
        @(posedge clk); #1 aw_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t6_bvalid", rsp.b_valid, 0);
        check("t6_doorbell", doorbell, 0);
        axi_read(BASE + 8, 0, d, rresp, la);
        check("t6_status", d, 64'h1);

        // randomized concurrent traffic
        gaps = 1;
        for (int it = 0; it < 400; it++) begin
            fork
                if ($urandom_range(0, 9) < 7)
                    axi_write(rnd_addr(0), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                              {$urandom, $urandom}, bresp2);
                if ($urandom_range(0, 9) < 7)
                    axi_read(rnd_addr(1), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                             d2, rresp2, la2);
            join
        end
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
